// File: rtl/launch_pkg.sv
// Shared launch definitions: sequencer state encodings and command limits.
// pwm_controller uses the same limits.
package launch_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAim     = 3'd1,
    StSpin    = 3'd2,
    StRelease = 3'd3,
    StCool    = 3'd4
  } seq_state_e;

  localparam logic [31:0] ANGLE_MAX = 32'd180;
  localparam logic [31:0] VEL_MAX   = 32'd100;

  // Unsigned saturation to an upper limit.
  function automatic logic [31:0] clamp_u32(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that times each launch phase; zero flags expiry.
module seq_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/launch_sequencer.sv
// Sequences one launch: aim settle, motor spin-up, arm release, cooldown.
// Commands are latched at phase transitions only and all outputs are registered.
module launch_sequencer
  import launch_pkg::*;
#(
  parameter int unsigned AIM_CYCLES     = 25_000_000,
  parameter int unsigned SPIN_CYCLES    = 50_000_000,
  parameter int unsigned RELEASE_CYCLES = 10_000_000,
  parameter int unsigned COOL_CYCLES    = 25_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fire,
  input  logic        abort,
  input  logic [31:0] angle,
  input  logic [31:0] velocity,
  output logic [31:0] theta_cmd,
  output logic [31:0] motor_cmd,
  output logic        arm_release,
  output logic        busy,
  output logic        launch_done,
  output logic [2:0]  seq_state
);

  localparam logic [CNT_W-1:0] AimLoad     = CNT_W'(AIM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SpinLoad    = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ReleaseLoad = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CoolLoad    = CNT_W'(COOL_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic             fire_q;
  logic [31:0]      theta_q, theta_d;
  logic [31:0]      motor_q, motor_d;
  logic             arm_q, arm_d;
  logic             done_q, done_d;
  logic             tmr_load, tmr_clear, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             fire_edge;

  assign fire_edge = fire & ~fire_q;

  seq_timer #(
    .CNT_W(CNT_W)
  ) u_seq_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .clear   (tmr_clear),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    theta_d   = theta_q;
    motor_d   = motor_q;
    arm_d     = arm_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_clear = 1'b0;

    // Abort outranks fire and any phase expiry; theta stays where it was aimed.
    if (state_q != StIdle && abort) begin
      state_d   = StIdle;
      motor_d   = '0;
      arm_d     = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (fire_edge && !abort) begin
            state_d  = StAim;
            theta_d  = clamp_u32(angle, ANGLE_MAX);
            motor_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = AimLoad;
          end
        end
        StAim: begin
          if (tmr_zero) begin
            state_d  = StSpin;
            motor_d  = clamp_u32(velocity, VEL_MAX);
            tmr_load = 1'b1;
            tmr_val  = SpinLoad;
          end
        end
        StSpin: begin
          if (tmr_zero) begin
            state_d  = StRelease;
            arm_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = ReleaseLoad;
          end
        end
        StRelease: begin
          if (tmr_zero) begin
            state_d  = StCool;
            arm_d    = 1'b0;
            motor_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = CoolLoad;
          end
        end
        StCool: begin
          if (tmr_zero) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d   = StIdle;
          motor_d   = '0;
          arm_d     = 1'b0;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      fire_q  <= 1'b1;
      theta_q <= '0;
      motor_q <= '0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire;
      theta_q <= theta_d;
      motor_q <= motor_d;
      arm_q   <= arm_d;
      done_q  <= done_d;
    end
  end

  assign theta_cmd   = theta_q;
  assign motor_cmd   = motor_q;
  assign arm_release = arm_q;
  assign busy        = (state_q != StIdle);
  assign launch_done = done_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_launch_sequencer.sv
// Scoreboard bench for launch_sequencer: the driver predicts each launch episode from
// phase-window arithmetic, the monitor measures episodes and compares when busy falls.
module tb_launch_sequencer;

  localparam int A   = 4;
  localparam int S   = 3;
  localparam int R   = 2;
  localparam int C   = 5;
  localparam int TOT = A + S + R + C;

  localparam int ModeNormal = 0;
  localparam int ModeAbort  = 1;
  localparam int ModeReset  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fire = 1'b1;
  logic        abort = 1'b0;
  logic [31:0] angle = '0;
  logic [31:0] velocity = '0;
  logic [31:0] theta_cmd, motor_cmd;
  logic        arm_release, busy, launch_done;
  logic [2:0]  seq_state;

  launch_sequencer #(
    .AIM_CYCLES    (A),
    .SPIN_CYCLES   (S),
    .RELEASE_CYCLES(R),
    .COOL_CYCLES   (C),
    .CNT_W         (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fire       (fire),
    .abort      (abort),
    .angle      (angle),
    .velocity   (velocity),
    .theta_cmd  (theta_cmd),
    .motor_cmd  (motor_cmd),
    .arm_release(arm_release),
    .busy       (busy),
    .launch_done(launch_done),
    .seq_state  (seq_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          busy_len;
    int          arm_len;
    int          motor_len;
    int          aim;
    int          spin;
    int          rel;
    int          cool;
    logic [31:0] theta;
    logic [31:0] motor;
    logic [31:0] theta_after;
    bit          done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles of window [a,b] (1-based busy cycle numbers) that happen within the first l cycles.
  function automatic int ovl(input int a, input int b, input int l);
    int hi;
    hi = (b < l) ? b : l;
    return (hi >= a) ? hi - a + 1 : 0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One launch; mode ModeAbort/ModeReset cuts it off after busy cycle k.
  task automatic run_launch(input logic [31:0] a, input logic [31:0] v, input int mode,
                            input int k, input bit refire);
    exp_t e;
    int   l;
    l             = (mode == ModeNormal) ? TOT : k;
    e.busy_len    = l;
    e.aim         = ovl(1, A, l);
    e.spin        = ovl(A + 1, A + S, l);
    e.rel         = ovl(A + S + 1, A + S + R, l);
    e.cool        = ovl(A + S + R + 1, TOT, l);
    e.arm_len     = e.rel;
    e.theta       = (a > 32'd180) ? 32'd180 : a;
    e.motor       = (l > A) ? ((v > 32'd100) ? 32'd100 : v) : 32'd0;
    e.motor_len   = (e.motor == 0) ? 0 : ovl(A + 1, A + S + R, l);
    e.theta_after = (mode == ModeReset) ? 32'd0 : e.theta;
    e.done        = (mode == ModeNormal);
    sb.push_back(e);

    angle    = a;
    velocity = v;
    fire     = 1'b1;
    step();
    for (int i = 1; i <= TOT; i++) begin
      if (mode != ModeNormal && i == k) begin
        if (mode == ModeAbort) abort = 1'b1;
        else begin
          reset = 1'b1;
          fire  = 1'b1;
        end
        step();
        abort = 1'b0;
        reset = 1'b0;
        break;
      end
      angle    = $urandom;
      velocity = (i == A) ? v : $urandom;
      if (refire && i == A + 1) fire = 1'b0;
      else if (refire && i == A + 2) fire = 1'b1;
      else if ($urandom_range(0, 3) == 0) fire = ~fire;
      step();
    end
    // After a reset, fire held high must not launch.
    if (mode == ModeReset) repeat (3) step();
    fire = 1'b0;
    repeat (1 + $urandom_range(0, 2)) step();
  endtask

  task automatic conflict();
    fire  = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (2) step();
    fire = 1'b0;
    step();
  endtask

  function automatic logic [31:0] pick_val(input logic [31:0] lim);
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, lim + 20);
      2:       return lim + 32'($urandom_range(0, 1));
      default: return 32'h8000_0000 | $urandom;
    endcase
  endfunction

  // Monitor
  bit          in_ep = 1'b0;
  int          blen, alen, mlen, stc0, stc1, stc2, stc3, stc4, other;
  logic [31:0] th0, mval;
  bit          tbad, mbad, dbad;

  always @(negedge clock) begin
    if (busy) begin
      if (!in_ep) begin
        in_ep = 1'b1;
        blen = 0; alen = 0; mlen = 0; mval = 0;
        stc0 = 0; stc1 = 0; stc2 = 0; stc3 = 0; stc4 = 0; other = 0;
        tbad = 1'b0; mbad = 1'b0; dbad = 1'b0;
        th0 = theta_cmd;
      end
      blen++;
      if (arm_release) alen++;
      if (motor_cmd != 0) begin
        mlen++;
        if (mval == 0) mval = motor_cmd;
        else if (motor_cmd != mval) mbad = 1'b1;
      end
      if (theta_cmd != th0) tbad = 1'b1;
      if (launch_done) dbad = 1'b1;
      case (seq_state)
        3'd0:    stc0++;
        3'd1:    stc1++;
        3'd2:    stc2++;
        3'd3:    stc3++;
        3'd4:    stc4++;
        default: other++;
      endcase
    end else if (in_ep) begin
      in_ep = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_launch", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("busy_len", blen, e.busy_len);
        chk("arm_len", alen, e.arm_len);
        chk("motor_len", mlen, e.motor_len);
        chk("motor_val", mval, e.motor);
        chk("motor_stable", {31'd0, mbad}, 32'd0);
        chk("theta_val", th0, e.theta);
        chk("theta_stable", {31'd0, tbad}, 32'd0);
        chk("done_in_busy", {31'd0, dbad}, 32'd0);
        chk("aim_cycles", stc1, e.aim);
        chk("spin_cycles", stc2, e.spin);
        chk("release_cycles", stc3, e.rel);
        chk("cool_cycles", stc4, e.cool);
        chk("bad_state_cycles", stc0 + other, 32'd0);
        chk("launch_done", {31'd0, launch_done}, {31'd0, e.done});
        chk("idle_theta", theta_cmd, e.theta_after);
        chk("idle_motor", motor_cmd, 32'd0);
        chk("idle_arm", {31'd0, arm_release}, 32'd0);
        chk("idle_state", {29'd0, seq_state}, 32'd0);
      end
    end else begin
      chk("spurious_done", {31'd0, launch_done}, 32'd0);
    end
  end

  initial begin
    // Reset with fire held high: outputs zero, and no launch afterwards.
    step();
    step();
    chk("rst_theta", theta_cmd, 32'd0);
    chk("rst_motor", motor_cmd, 32'd0);
    chk("rst_arm", {31'd0, arm_release}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, launch_done}, 32'd0);
    chk("rst_state", {29'd0, seq_state}, 32'd0);
    reset = 1'b0;
    repeat (3) step();
    chk("fire_held_no_launch", {31'd0, busy}, 32'd0);
    fire = 1'b0;
    step();

    run_launch(32'd45, 32'd60, ModeNormal, 0, 1'b0);
    run_launch(32'd200, 32'hFFFF_FFFF, ModeNormal, 0, 1'b0);
    run_launch(32'd90, 32'd30, ModeNormal, 0, 1'b1);
    run_launch(32'd10, 32'd75, ModeNormal, 0, 1'b0);
    run_launch(32'd120, 32'd50, ModeAbort, A + 2, 1'b0);
    run_launch(32'd33, 32'd44, ModeReset, A + S + 1, 1'b0);
    run_launch(32'd66, 32'd77, ModeNormal, 0, 1'b0);
    conflict();
    chk("conflict_idle", {31'd0, busy}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 5);
      if (sel == 5) conflict();
      else run_launch(pick_val(32'd180), pick_val(32'd100),
                      (sel == 3) ? ModeAbort : (sel == 4) ? ModeReset : ModeNormal,
                      $urandom_range(1, TOT), 1'($urandom_range(0, 1)));
    end

    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("final_idle", {31'd0, busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
